// File: rtl/vx_commit_counters.sv
// Purpose : mcycle/minstret counters fed by the commit report, served over a CSR req/rsp port.
// Latency : a CSR request accepted at edge N presents its response after edge N (1 cycle).
// Backpr. : one response in flight; requests are refused while a response waits on rsp_ready.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-low reset
//   i_cmt_valid/i_cmt_size   threads retired this cycle (0..3*NUM_THREADS)
//   i_csr_req_*/o_csr_req_*  CSR request (addr, write, data) valid/ready
//   o_csr_rsp_*/i_csr_rsp_*  CSR response (data, err) valid/ready
//   o_cycle, o_instret       raw 64-bit counter values for perf/debug taps
module vx_commit_counters #(
    parameter  int NUM_THREADS = 4,
    localparam int CMTW        = $clog2(3*NUM_THREADS+1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_cmt_valid,
    input  logic [CMTW-1:0] i_cmt_size,
    input  logic            i_csr_req_valid,
    output logic            o_csr_req_ready,
    input  logic [11:0]     i_csr_req_addr,
    input  logic            i_csr_req_write,
    input  logic [31:0]     i_csr_req_data,
    output logic            o_csr_rsp_valid,
    input  logic            i_csr_rsp_ready,
    output logic [31:0]     o_csr_rsp_data,
    output logic            o_csr_rsp_err,
    output logic [63:0]     o_cycle,
    output logic [63:0]     o_instret
);

    localparam logic [CMTW-1:0] CMT_MAX = CMTW'(3*NUM_THREADS);

    logic [63:0] r_cycle;
    logic [63:0] r_instret;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_req_fire;
    logic        w_legal;
    logic        w_writable;
    logic        w_sel_instret;
    logic        w_sel_hi;
    logic        w_wr_ok;
    logic [63:0] w_sel_val;
    logic [31:0] w_rd_half;
    logic [63:0] w_cycle_inc;
    logic [63:0] w_instret_inc;
    logic [63:0] w_cycle_nxt;
    logic [63:0] w_instret_nxt;

    assign o_csr_req_ready = i_reset && (!r_rsp_valid || i_csr_rsp_ready);
    assign w_req_fire      = i_csr_req_valid && o_csr_req_ready;

    // Address decode: 0xB.. are the machine-mode read/write CSRs,
    // 0xC.. are the read-only user aliases of the same halves.
    always_comb begin
        w_legal       = 1'b0;
        w_writable    = 1'b0;
        w_sel_instret = 1'b0;
        w_sel_hi      = 1'b0;
        case (i_csr_req_addr)
            12'hB00: begin w_legal = 1'b1; w_writable = 1'b1; end
            12'hB80: begin w_legal = 1'b1; w_writable = 1'b1; w_sel_hi = 1'b1; end
            12'hB02: begin w_legal = 1'b1; w_writable = 1'b1; w_sel_instret = 1'b1; end
            12'hB82: begin w_legal = 1'b1; w_writable = 1'b1; w_sel_instret = 1'b1; w_sel_hi = 1'b1; end
            12'hC00: begin w_legal = 1'b1; end
            12'hC80: begin w_legal = 1'b1; w_sel_hi = 1'b1; end
            12'hC02: begin w_legal = 1'b1; w_sel_instret = 1'b1; end
            12'hC82: begin w_legal = 1'b1; w_sel_instret = 1'b1; w_sel_hi = 1'b1; end
            default: begin w_legal = 1'b0; end
        endcase
    end

    assign w_wr_ok   = w_req_fire && i_csr_req_write && w_legal && w_writable;
    assign w_sel_val = w_sel_instret ? r_instret : r_cycle;
    assign w_rd_half = w_sel_hi ? w_sel_val[63:32] : w_sel_val[31:0];

    assign w_cycle_inc   = r_cycle + 64'd1;
    assign w_instret_inc = r_instret + (i_cmt_valid ? 64'(i_cmt_size) : 64'd0);

    // A CSR write owns its half for that edge. Writing the high half keeps the
    // low half counting but drops its carry; writing the low half freezes the
    // high half (and, for minstret, discards that cycle's commit).
    always_comb begin
        w_cycle_nxt   = w_cycle_inc;
        w_instret_nxt = w_instret_inc;
        if (w_wr_ok && !w_sel_instret) begin
            if (w_sel_hi) w_cycle_nxt = {i_csr_req_data, w_cycle_inc[31:0]};
            else          w_cycle_nxt = {r_cycle[63:32], i_csr_req_data};
        end
        if (w_wr_ok && w_sel_instret) begin
            if (w_sel_hi) w_instret_nxt = {i_csr_req_data, w_instret_inc[31:0]};
            else          w_instret_nxt = {r_instret[63:32], i_csr_req_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cycle     <= 64'd0;
            r_instret   <= 64'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_cycle   <= w_cycle_nxt;
            r_instret <= w_instret_nxt;
            if (w_req_fire) begin
                r_rsp_valid <= 1'b1;
                // Illegal addresses return zero; legal ones (including
                // rejected alias writes) return the pre-edge value.
                r_rsp_data  <= w_legal ? w_rd_half : 32'd0;
                r_rsp_err   <= !w_legal || (i_csr_req_write && !w_writable);
            end else if (i_csr_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_csr_rsp_valid = r_rsp_valid;
    assign o_csr_rsp_data  = r_rsp_data;
    assign o_csr_rsp_err   = r_rsp_err;
    assign o_cycle         = r_cycle;
    assign o_instret       = r_instret;

    // Commit stage never retires more than 3 per thread in a cycle.
    a_cmt_size_legal: assert property (@(posedge i_clk) disable iff (!i_reset)
        i_cmt_valid |-> (i_cmt_size <= CMT_MAX));

endmodule

// File: tb/tb_vx_commit_counters.sv
module tb_vx_commit_counters;

    logic        clk;
    logic        rst_n;
    logic        cmt_valid;
    logic [3:0]  cmt_size;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        req_write;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [63:0] cycle;
    logic [63:0] instret;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    rsp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] n_edges = 64'd0;

    vx_commit_counters #(.NUM_THREADS(4)) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_cmt_valid     (cmt_valid),
        .i_cmt_size      (cmt_size),
        .i_csr_req_valid (req_valid),
        .o_csr_req_ready (req_ready),
        .i_csr_req_addr  (req_addr),
        .i_csr_req_write (req_write),
        .i_csr_req_data  (req_data),
        .o_csr_rsp_valid (rsp_valid),
        .i_csr_rsp_ready (rsp_ready),
        .o_csr_rsp_data  (rsp_data),
        .o_csr_rsp_err   (rsp_err),
        .o_cycle         (cycle),
        .o_instret       (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference count of edges since reset release (valid until mcycle is written).
    always @(posedge clk) n_edges <= rst_n ? n_edges + 64'd1 : 64'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge, with the response checked.
    task automatic req(input string tag, input logic [11:0] a, input logic w,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        int   t;
        rsp_t r;
        req_addr  = a;
        req_write = w;
        req_data  = d;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check({tag, "_accept_timeout"}, 64'(req_ready), 64'd1);
        sb.push_back('{d: exp_d, e: exp_e});
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        if (rsp_valid && sb.size() > 0) begin
            r = sb.pop_front();
            check({tag, "_rsp_data"}, 64'(rsp_data), 64'(r.d));
            check({tag, "_rsp_err"}, 64'(rsp_err), 64'(r.e));
        end
    endtask

    initial begin
        logic [63:0] snap;
        rst_n     = 1'b0;
        cmt_valid = 1'b0;
        cmt_size  = 4'd0;
        req_valid = 1'b0;
        req_addr  = 12'd0;
        req_write = 1'b0;
        req_data  = 32'd0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_cycle", cycle, 64'd0);
        check("reset_instret", instret, 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);

        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_cycle", cycle, 64'd10);
        check("idle_instret", instret, 64'd0);
        check("idle_rsp_valid", 64'(rsp_valid), 64'd0);

        // Commits 4, 12, 0
        cmt_valid = 1'b1; cmt_size = 4'd4;
        @(negedge clk); cmt_size = 4'd12;
        @(negedge clk); cmt_size = 4'd0;
        @(negedge clk); cmt_valid = 1'b0;
        check("commit_sum", instret, 64'd16);
        req("rd_c02", 12'hC02, 1'b0, 32'd0, 32'd16, 1'b0);

        // Carry propagation in minstret
        req("wr_b02", 12'hB02, 1'b1, 32'hFFFF_FFFE, 32'd16, 1'b0);
        req("wr_b82", 12'hB82, 1'b1, 32'd0, 32'd0, 1'b0);
        cmt_valid = 1'b1; cmt_size = 4'd4;
        @(negedge clk); cmt_valid = 1'b0;
        check("instret_carry", instret, 64'h1_0000_0002);
        req("rd_b82", 12'hB82, 1'b0, 32'd0, 32'd1, 1'b0);

        // Low-half write coincident with a commit discards the commit
        cmt_valid = 1'b1; cmt_size = 4'd5;
        req("wr_b02_cmt", 12'hB02, 1'b1, 32'd7, 32'd2, 1'b0);
        cmt_valid = 1'b0;
        check("wr_lo_drops_cmt", instret, 64'h1_0000_0007);

        // Read coincident with a commit returns the pre-add value
        cmt_valid = 1'b1; cmt_size = 4'd3;
        req("rd_c02_cmt", 12'hC02, 1'b0, 32'd0, 32'd7, 1'b0);
        cmt_valid = 1'b0;
        check("cmt_after_read", instret, 64'h1_0000_000A);

        // mcycle high write with low half at all-ones: carry discarded
        snap = n_edges;
        req("wr_b00", 12'hB00, 1'b1, 32'hFFFF_FFFE, snap[31:0], 1'b0);
        @(negedge clk);
        check("cycle_lo_ones", 64'(cycle[31:0]), 64'hFFFF_FFFF);
        req("wr_b80", 12'hB80, 1'b1, 32'd5, 32'd0, 1'b0);
        check("cycle_hi_write", cycle, 64'h5_0000_0000);

        // Alias write rejected, illegal address
        req("wr_c02", 12'hC02, 1'b1, 32'h55, 32'hA, 1'b1);
        check("alias_no_change", instret, 64'h1_0000_000A);
        req("rd_123", 12'h123, 1'b0, 32'd0, 32'd0, 1'b1);
        req("wr_123", 12'h123, 1'b1, 32'h77, 32'd0, 1'b1);
        check("illegal_no_change", instret, 64'h1_0000_000A);

        // Response stall, then reset mid-stall
        @(negedge clk);
        rsp_ready = 1'b0;
        req("rd_c82_stall", 12'hC82, 1'b0, 32'd0, 32'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall_rsp_data", 64'(rsp_data), 64'd1);
            @(negedge clk);
        end
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 12'hB00;
        req_write = 1'b0;
        @(negedge clk);
        sb.delete();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_cycle", cycle, 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
        check("post_rst_cycle", cycle, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
